quadrature_generator: RTL

- Drives a two-phase quadrature (Gray-code) A/B pair, the transmit side of the rotary-encoder decoding path.
- Callers request steps with single-cycle up/down pulses. The block queues them as a signed backlog and emits one A/B transition per STEP_DIV clocks until the backlog is empty.
- Used on-board to drive the decoder's A/B inputs (loopback or jumpered pins) for self-test. It can also inject one illegal double-edge to exercise the decoder error toggle.

---
 rtl/quadrature_generator.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/quadrature_generator.sv
// Quadrature A/B step generator: queues signed step requests as a saturating backlog
// and emits one Gray-code transition every STEP_DIV clocks, with optional illegal-edge injection.
module quadrature_generator #(
    parameter int unsigned STEP_DIV  = 1000,
    parameter int unsigned DIV_BITS  = 16,
    parameter int unsigned PEND_BITS = 8,
    parameter logic [1:0]  RESET_AB  = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_up,
    input  logic       step_down,
    input  logic       inject_err,
    input  logic       clr_ovf,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic [7:0] position,
    output logic       ovf
);

    localparam int unsigned EXT_BITS = PEND_BITS + 2;
    localparam logic [DIV_BITS-1:0]        DIV_LAST  = DIV_BITS'(STEP_DIV - 1);
    localparam logic [DIV_BITS-1:0]        DIV_ONE   = DIV_BITS'(1);
    localparam logic [DIV_BITS-1:0]        DIV_ZERO  = {DIV_BITS{1'b0}};
    localparam logic signed [EXT_BITS-1:0] PEND_MAX  = EXT_BITS'((2 ** (PEND_BITS - 1)) - 1);
    localparam logic signed [EXT_BITS-1:0] PEND_MIN  = ~PEND_MAX;
    localparam logic signed [EXT_BITS-1:0] PEND_ONE  = EXT_BITS'(1);
    localparam logic signed [EXT_BITS-1:0] PEND_ZERO = {EXT_BITS{1'b0}};
    localparam logic [PEND_BITS-1:0]       BL_ZERO   = {PEND_BITS{1'b0}};

    // Forward order 00 -> 10 -> 11 -> 01 -> 00, as {a,b}
    function automatic logic [1:0] fwd_state(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = 2'b10;
            2'b10:   nxt = 2'b11;
            2'b11:   nxt = 2'b01;
            2'b01:   nxt = 2'b00;
            default: nxt = ab;
        endcase
        return nxt;
    endfunction

    function automatic logic [1:0] rev_state(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b11;
            2'b11:   nxt = 2'b10;
            2'b10:   nxt = 2'b00;
            default: nxt = ab;
        endcase
        return nxt;
    endfunction

    logic [1:0]                  ab_r;
    logic [7:0]                  position_r;
    logic                        busy_r;
    logic                        ovf_r;
    logic                        inj_r;
    logic signed [PEND_BITS-1:0] backlog_r;
    logic [DIV_BITS-1:0]         div_r;

    logic                        tick_s;
    logic                        inj_tick_s;
    logic                        fwd_tick_s;
    logic                        rev_tick_s;
    logic signed [EXT_BITS-1:0]  pend_ext_s;
    logic signed [EXT_BITS-1:0]  step_term_s;
    logic signed [EXT_BITS-1:0]  consume_term_s;
    logic signed [EXT_BITS-1:0]  pend_sum_s;
    logic signed [PEND_BITS-1:0] backlog_nxt_s;
    logic                        sat_s;
    logic [1:0]                  ab_nxt_s;
    logic [7:0]                  position_nxt_s;
    logic                        inj_nxt_s;
    logic [DIV_BITS-1:0]         div_nxt_s;
    logic                        busy_nxt_s;
    logic                        ovf_nxt_s;

    // An injection outranks queued steps; the backlog sign picks the direction.
    assign tick_s     = busy_r && (div_r == DIV_LAST);
    assign inj_tick_s = tick_s && inj_r;
    assign fwd_tick_s = tick_s && !inj_r && !backlog_r[PEND_BITS-1] && (backlog_r != BL_ZERO);
    assign rev_tick_s = tick_s && !inj_r && backlog_r[PEND_BITS-1];

    assign pend_ext_s     = {{2{backlog_r[PEND_BITS-1]}}, backlog_r};
    assign step_term_s    = (step_up ? PEND_ONE : PEND_ZERO) - (step_down ? PEND_ONE : PEND_ZERO);
    assign consume_term_s = fwd_tick_s ? PEND_ONE : (rev_tick_s ? -PEND_ONE : PEND_ZERO);
    assign pend_sum_s     = pend_ext_s + step_term_s - consume_term_s;

    // Clamp the widened backlog sum to the signed range and flag any dropped request
    always_comb begin
        backlog_nxt_s = pend_sum_s[PEND_BITS-1:0];
        sat_s         = 1'b0;
        if (pend_sum_s > PEND_MAX) begin
            backlog_nxt_s = PEND_MAX[PEND_BITS-1:0];
            sat_s         = 1'b1;
        end else if (pend_sum_s < PEND_MIN) begin
            backlog_nxt_s = PEND_MIN[PEND_BITS-1:0];
            sat_s         = 1'b1;
        end else begin
            backlog_nxt_s = pend_sum_s[PEND_BITS-1:0];
            sat_s         = 1'b0;
        end
    end

    // Phase and position update on a tick
    always_comb begin
        ab_nxt_s       = ab_r;
        position_nxt_s = position_r;
        if (inj_tick_s) begin
            ab_nxt_s       = ~ab_r;
            position_nxt_s = position_r;
        end else if (fwd_tick_s) begin
            ab_nxt_s       = fwd_state(ab_r);
            position_nxt_s = position_r + 8'd1;
        end else if (rev_tick_s) begin
            ab_nxt_s       = rev_state(ab_r);
            position_nxt_s = position_r - 8'd1;
        end else begin
            ab_nxt_s       = ab_r;
            position_nxt_s = position_r;
        end
    end

    // Injection flag, divider, sticky overflow and busy next-state
    always_comb begin
        inj_nxt_s = inj_r;
        if (inj_tick_s) begin
            inj_nxt_s = 1'b0;
        end else if (inject_err) begin
            inj_nxt_s = 1'b1;
        end else begin
            inj_nxt_s = inj_r;
        end

        // Registered busy gates the divider, so it stays at 0 on the cycle a request arrives.
        div_nxt_s = div_r;
        if (!busy_r || tick_s) begin
            div_nxt_s = DIV_ZERO;
        end else begin
            div_nxt_s = div_r + DIV_ONE;
        end

        ovf_nxt_s = ovf_r;
        if (sat_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end

        busy_nxt_s = (backlog_nxt_s != BL_ZERO) || inj_nxt_s;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ab_r       <= RESET_AB;
            position_r <= 8'd0;
            busy_r     <= 1'b0;
            ovf_r      <= 1'b0;
            inj_r      <= 1'b0;
            backlog_r  <= BL_ZERO;
            div_r      <= DIV_ZERO;
        end else begin
            ab_r       <= ab_nxt_s;
            position_r <= position_nxt_s;
            busy_r     <= busy_nxt_s;
            ovf_r      <= ovf_nxt_s;
            inj_r      <= inj_nxt_s;
            backlog_r  <= backlog_nxt_s;
            div_r      <= div_nxt_s;
        end
    end

    assign a        = ab_r[1];
    assign b        = ab_r[0];
    assign busy     = busy_r;
    assign position = position_r;
    assign ovf      = ovf_r;

endmodule
